// File: rtl/rd53_conf_pkg.sv
// Shared types and constants for the core configuration bus: pixel address
// layout, broadcast address, and the configuration sequencer state encoding.
package rd53_conf_pkg;

  localparam int REGIONS_PER_CORE  = 16;
  localparam int PIXELS_PER_REGION = 4;

  localparam logic [1:0]  LAST_PIXEL     = 2'(PIXELS_PER_REGION - 1);
  localparam logic [3:0]  LAST_REGION    = 4'(REGIONS_PER_CORE - 1);
  localparam logic [11:0] CONF_BROADCAST = 12'hFFF;

  typedef struct packed {
    logic [5:0] row;
    logic [3:0] region;
    logic [1:0] pixel;
  } conf_addr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RDWAIT,
    ST_DONE
  } seq_state_e;

  // Phases during which a write beat owns the write-data lines.
  function automatic logic is_write_phase(input seq_state_e s);
    return (s == ST_SETUP) || (s == ST_STROBE) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/conf_addr_incr.sv
// Combinational next-pixel address: pixel, then region, then row, wrapping
// past MAX_ROW back to row 0 and flagging the wrap.
module conf_addr_incr
  import rd53_conf_pkg::*;
#(
  parameter int MAX_ROW = 47
) (
  input  conf_addr_t addr,
  output conf_addr_t addr_next,
  output logic       wrap
);

  // NOTE: every output gets a default first so no path through the
  // conditionals leaves a value unassigned and infers a latch.
  always_comb begin
    addr_next = addr;
    wrap      = 1'b0;
    if (addr.pixel != LAST_PIXEL) begin
      addr_next.pixel = addr.pixel + 2'd1;
    end else begin
      addr_next.pixel = '0;
      if (addr.region != LAST_REGION) begin
        addr_next.region = addr.region + 4'd1;
      end else begin
        addr_next.region = '0;
        if (int'(addr.row) >= MAX_ROW) begin
          addr_next.row = '0;
          wrap          = 1'b1;
        end else begin
          addr_next.row = addr.row + 6'd1;
        end
      end
    end
  end

endmodule

// File: rtl/pixel_conf_sequencer.sv
// Burst sequencer for per-pixel configuration writes/readbacks with
// setup/strobe/hold timing on the shared core configuration bus.
module pixel_conf_sequencer
  import rd53_conf_pkg::*;
#(
  parameter int SETUP_CYC = 1,
  parameter int WR_CYC    = 1,
  parameter int HOLD_CYC  = 1,
  parameter int RD_CYC    = 2,
  parameter int MAX_ROW   = 47
) (
  input  logic        Clk,
  input  logic        ResetB,
  input  logic        CmdValid,
  output logic        CmdReady,
  input  logic        CmdWrite,
  input  logic [11:0] CmdAddr,
  input  logic [7:0]  CmdData,
  input  logic [5:0]  CmdLen,
  input  logic        Abort,
  output logic [11:0] AddressConfOut,
  output logic        ConfWrOut,
  output logic [7:0]  DataConfWr,
  input  logic [7:0]  DataConfRegions,
  output logic        RdValid,
  output logic [7:0]  RdData,
  output logic [11:0] RdAddr,
  output logic        Busy,
  output logic        ErrPulse,
  output logic        WrapFlag
);

  localparam logic [2:0] SETUP_LD = 3'(SETUP_CYC - 1);
  localparam logic [2:0] WR_LD    = 3'(WR_CYC - 1);
  localparam logic [2:0] HOLD_LD  = 3'(HOLD_CYC - 1);
  localparam logic [2:0] RD_LD    = 3'(RD_CYC - 1);

  seq_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [5:0] beats_q, beats_d;
  conf_addr_t addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       write_q, write_d;
  logic       abort_q, abort_d;
  logic       wrap_q, wrap_d;
  logic       err_d;
  logic       beat_end;

  conf_addr_t cmd_addr;
  conf_addr_t addr_inc;
  logic       addr_wrap;
  logic       cmd_bcast;
  logic       cmd_reject;
  logic       rd_fire;

  assign cmd_addr   = conf_addr_t'(CmdAddr);
  assign cmd_bcast  = (CmdAddr == CONF_BROADCAST);
  assign cmd_reject = (!CmdWrite && cmd_bcast) ||
                      (!cmd_bcast && int'(cmd_addr.row) > MAX_ROW);
  assign rd_fire    = (state_q == ST_RDWAIT) && (cnt_q == 3'd0);

  conf_addr_incr #(.MAX_ROW(MAX_ROW)) u_addr_incr (
    .addr      (addr_q),
    .addr_next (addr_inc),
    .wrap      (addr_wrap)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    beats_d  = beats_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    abort_d  = abort_q;
    wrap_d   = wrap_q;
    err_d    = 1'b0;
    beat_end = 1'b0;

    // Abort is latched so it survives until the current beat completes.
    if (state_q != ST_IDLE && Abort) abort_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (CmdValid) begin
          if (cmd_reject) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_SETUP;
            cnt_d   = SETUP_LD;
            addr_d  = cmd_addr;
            wdata_d = CmdData;
            write_d = CmdWrite;
            beats_d = cmd_bcast ? 6'd0 : CmdLen;
            abort_d = 1'b0;
            wrap_d  = 1'b0;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else if (write_q) begin
          state_d = ST_STROBE;
          cnt_d   = WR_LD;
        end else begin
          state_d = ST_RDWAIT;
          cnt_d   = RD_LD;
        end
      end
      ST_STROBE: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end
      end
      ST_HOLD, ST_RDWAIT: begin
        if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
        else               beat_end = 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Next beat's SETUP follows immediately; the address only advances
    // when another beat actually follows.
    if (beat_end) begin
      if (beats_q == 6'd0 || abort_q || Abort) begin
        state_d = ST_DONE;
      end else begin
        state_d = ST_SETUP;
        cnt_d   = SETUP_LD;
        beats_d = beats_q - 6'd1;
        addr_d  = addr_inc;
        if (addr_wrap) wrap_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments; bus outputs are
  // registered from the next-state values so they are glitch-free and
  // line up with the state they belong to.
  always_ff @(posedge Clk or negedge ResetB) begin
    if (!ResetB) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      beats_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      abort_q    <= 1'b0;
      wrap_q     <= 1'b0;
      CmdReady   <= 1'b1;
      Busy       <= 1'b0;
      ConfWrOut  <= 1'b0;
      DataConfWr <= '0;
      ErrPulse   <= 1'b0;
      RdValid    <= 1'b0;
      RdData     <= '0;
      RdAddr     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      beats_q    <= beats_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      abort_q    <= abort_d;
      wrap_q     <= wrap_d;
      CmdReady   <= (state_d == ST_IDLE);
      Busy       <= (state_d != ST_IDLE);
      ConfWrOut  <= (state_d == ST_STROBE);
      DataConfWr <= (write_d && is_write_phase(state_d)) ? wdata_d : 8'h00;
      ErrPulse   <= err_d;
      RdValid    <= rd_fire;
      if (rd_fire) begin
        RdData <= DataConfRegions;
        RdAddr <= addr_q;
      end
    end
  end

  assign AddressConfOut = addr_q;
  assign WrapFlag       = wrap_q;

endmodule

// File: tb/tb_pixel_conf_sequencer.sv
// Scoreboard bench for pixel_conf_sequencer: directed commands push expected
// strobes/readbacks/errors; a negedge monitor pops and compares them.
module tb_pixel_conf_sequencer;

  localparam int WR_W = 1;

  logic        Clk = 1'b0;
  logic        ResetB = 1'b0;
  logic        CmdValid = 1'b0;
  logic        CmdReady;
  logic        CmdWrite = 1'b0;
  logic [11:0] CmdAddr = '0;
  logic [7:0]  CmdData = '0;
  logic [5:0]  CmdLen = '0;
  logic        Abort = 1'b0;
  logic [11:0] AddressConfOut;
  logic        ConfWrOut;
  logic [7:0]  DataConfWr;
  logic [7:0]  DataConfRegions = '0;
  logic        RdValid;
  logic [7:0]  RdData;
  logic [11:0] RdAddr;
  logic        Busy;
  logic        ErrPulse;
  logic        WrapFlag;

  pixel_conf_sequencer dut (
    .Clk             (Clk),
    .ResetB          (ResetB),
    .CmdValid        (CmdValid),
    .CmdReady        (CmdReady),
    .CmdWrite        (CmdWrite),
    .CmdAddr         (CmdAddr),
    .CmdData         (CmdData),
    .CmdLen          (CmdLen),
    .Abort           (Abort),
    .AddressConfOut  (AddressConfOut),
    .ConfWrOut       (ConfWrOut),
    .DataConfWr      (DataConfWr),
    .DataConfRegions (DataConfRegions),
    .RdValid         (RdValid),
    .RdData          (RdData),
    .RdAddr          (RdAddr),
    .Busy            (Busy),
    .ErrPulse        (ErrPulse),
    .WrapFlag        (WrapFlag)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  data;
    int          cyc;
  } ev_t;

  ev_t str_q[$];
  ev_t rd_q[$];
  int  err_q[$];

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  logic        in_str = 1'b0;
  int          str_w = 0;
  logic [11:0] s_addr, prev_addr = '0;
  logic [7:0]  s_data, prev_data = '0;

  always @(negedge Clk) begin
    ev_t e;
    if (!ResetB) begin
      in_str = 1'b0;
      str_w  = 0;
    end else begin
      if (ConfWrOut) begin
        if (!in_str) begin
          if (str_q.size() == 0) begin
            check("unexpected_strobe", 32'd1, 32'd0);
          end else begin
            e = str_q.pop_front();
            check("strobe_addr", 32'(AddressConfOut), 32'(e.addr));
            check("strobe_data", 32'(DataConfWr), 32'(e.data));
            check("strobe_cycle", 32'(cyc), 32'(e.cyc));
          end
          check("setup_addr_stable", 32'(prev_addr), 32'(AddressConfOut));
          check("setup_data_stable", 32'(prev_data), 32'(DataConfWr));
          in_str = 1'b1;
          str_w  = 1;
          s_addr = AddressConfOut;
          s_data = DataConfWr;
        end else begin
          str_w++;
        end
      end else if (in_str) begin
        check("strobe_width", 32'(str_w), 32'(WR_W));
        check("hold_addr", 32'(AddressConfOut), 32'(s_addr));
        check("hold_data", 32'(DataConfWr), 32'(s_data));
        in_str = 1'b0;
      end

      if (RdValid) begin
        if (rd_q.size() == 0) begin
          check("unexpected_rdvalid", 32'd1, 32'd0);
        end else begin
          e = rd_q.pop_front();
          check("rd_addr", 32'(RdAddr), 32'(e.addr));
          check("rd_data", 32'(RdData), 32'(e.data));
          check("rd_cycle", 32'(cyc), 32'(e.cyc));
        end
      end

      if (ErrPulse) begin
        if (err_q.size() == 0) check("unexpected_err", 32'd1, 32'd0);
        else check("err_cycle", 32'(cyc), 32'(err_q.pop_front()));
      end
    end
    prev_addr = AddressConfOut;
    prev_data = DataConfWr;
  end

  // ---------------- driver helpers ----------------
  task automatic wait_ready();
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (CmdReady) return;
    end
    check("ready_timeout", 32'd0, 32'd1);
  endtask

  // Presents a command at a negedge; the following posedge is the accept edge.
  task automatic issue(input logic wr, input logic [11:0] addr, input logic [7:0] data,
                       input logic [5:0] len, output int acc);
    wait_ready();
    CmdWrite = wr;
    CmdAddr  = addr;
    CmdData  = data;
    CmdLen   = len;
    CmdValid = 1'b1;
    acc      = cyc;
  endtask

  task automatic release_cmd();
    @(negedge Clk);
    CmdValid = 1'b0;
  endtask

  task automatic step_to(input int target);
    for (int i = 0; i < 200 && cyc < target; i++) @(negedge Clk);
  endtask

  task automatic push_str(input logic [11:0] a, input logic [7:0] d, input int c);
    ev_t e;
    e.addr = a; e.data = d; e.cyc = c;
    str_q.push_back(e);
  endtask

  task automatic push_rd(input logic [11:0] a, input logic [7:0] d, input int c);
    ev_t e;
    e.addr = a; e.data = d; e.cyc = c;
    rd_q.push_back(e);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    logic [11:0] burst_addr [4];
    burst_addr[0] = 12'h03E; burst_addr[1] = 12'h03F;
    burst_addr[2] = 12'h040; burst_addr[3] = 12'h041;

    repeat (3) @(negedge Clk);
    check("rst_cmdready", 32'(CmdReady), 32'd1);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_confwr", 32'(ConfWrOut), 32'd0);
    check("rst_addr", 32'(AddressConfOut), 32'h0);
    check("rst_wdata", 32'(DataConfWr), 32'h0);
    check("rst_rdvalid", 32'(RdValid), 32'd0);
    check("rst_err", 32'(ErrPulse), 32'd0);
    check("rst_wrap", 32'(WrapFlag), 32'd0);
    ResetB = 1'b1;

    // Single write: strobe in cycle 2, DONE in 4, ready in 5.
    issue(1'b1, 12'h0A7, 8'h5C, 6'd0, acc);
    push_str(12'h0A7, 8'h5C, acc + 2);
    release_cmd();
    for (int k = 1; k <= 3; k++) begin
      step_to(acc + k);
      check("single_addr", 32'(AddressConfOut), 32'h0A7);
      check("single_data", 32'(DataConfWr), 32'h5C);
    end
    step_to(acc + 4);
    check("single_done_busy", 32'(Busy), 32'd1);
    check("single_done_ready", 32'(CmdReady), 32'd0);
    check("single_done_wdata", 32'(DataConfWr), 32'h0);
    check("single_idle_addr_hold", 32'(AddressConfOut), 32'h0A7);
    step_to(acc + 5);
    check("single_ready", 32'(CmdReady), 32'd1);

    // Write burst of four beats, strobes three cycles apart.
    issue(1'b1, 12'h03E, 8'h11, 6'd3, acc);
    for (int k = 0; k < 4; k++) push_str(burst_addr[k], 8'h11, acc + 2 + 3 * k);
    release_cmd();
    step_to(acc + 13);
    check("burst_done_busy", 32'(Busy), 32'd1);
    check("burst_wrap", 32'(WrapFlag), 32'd0);

    // Read burst of two beats.
    DataConfRegions = 8'hA5;
    issue(1'b0, 12'h000, 8'hFF, 6'd1, acc);
    push_rd(12'h000, 8'hA5, acc + 4);
    push_rd(12'h001, 8'h3C, acc + 7);
    release_cmd();
    check("read_wdata_zero", 32'(DataConfWr), 32'h0);
    step_to(acc + 4);
    DataConfRegions = 8'h3C;
    step_to(acc + 8);
    check("read_ready", 32'(CmdReady), 32'd1);

    // Wrap past the last row.
    issue(1'b1, {6'd47, 4'd15, 2'd3}, 8'h77, 6'd1, acc);
    push_str(12'hBFF, 8'h77, acc + 2);
    push_str(12'h000, 8'h77, acc + 5);
    release_cmd();
    step_to(acc + 3);
    check("wrap_before", 32'(WrapFlag), 32'd0);
    step_to(acc + 4);
    check("wrap_set", 32'(WrapFlag), 32'd1);
    step_to(acc + 8);
    check("wrap_sticky_idle", 32'(WrapFlag), 32'd1);

    // Broadcast read and out-of-range row are rejected.
    issue(1'b0, 12'hFFF, 8'h00, 6'd0, acc);
    err_q.push_back(acc + 1);
    release_cmd();
    check("bcast_rd_ready", 32'(CmdReady), 32'd1);
    check("bcast_rd_busy", 32'(Busy), 32'd0);
    issue(1'b1, 12'hC00, 8'h12, 6'd0, acc);
    err_q.push_back(acc + 1);
    release_cmd();
    check("badrow_busy", 32'(Busy), 32'd0);

    // Broadcast write: one strobe regardless of CmdLen; clears WrapFlag.
    issue(1'b1, 12'hFFF, 8'h99, 6'd5, acc);
    push_str(12'hFFF, 8'h99, acc + 2);
    release_cmd();
    check("wrap_cleared", 32'(WrapFlag), 32'd0);
    step_to(acc + 4);
    check("bcast_wr_done", 32'(Busy), 32'd1);
    step_to(acc + 5);
    check("bcast_wr_ready", 32'(CmdReady), 32'd1);

    // Abort during the strobe of beat 0 of an 8-beat write.
    issue(1'b1, 12'h100, 8'hE4, 6'd7, acc);
    push_str(12'h100, 8'hE4, acc + 2);
    release_cmd();
    step_to(acc + 2);
    Abort = 1'b1;
    step_to(acc + 3);
    Abort = 1'b0;
    check("abort_hold_busy", 32'(Busy), 32'd1);
    step_to(acc + 4);
    check("abort_done_ready", 32'(CmdReady), 32'd0);
    step_to(acc + 5);
    check("abort_idle_ready", 32'(CmdReady), 32'd1);
    step_to(acc + 10);

    // Reset asserted mid-strobe.
    issue(1'b1, 12'h200, 8'h3A, 6'd0, acc);
    push_str(12'h200, 8'h3A, acc + 2);
    release_cmd();
    step_to(acc + 2);
    #2 ResetB = 1'b0;
    #1;
    check("rst_mid_confwr", 32'(ConfWrOut), 32'd0);
    check("rst_mid_ready", 32'(CmdReady), 32'd1);
    @(negedge Clk);
    #2 ResetB = 1'b1;
    repeat (4) @(negedge Clk);

    check("str_queue_empty", 32'(str_q.size()), 32'd0);
    check("rd_queue_empty", 32'(rd_q.size()), 32'd0);
    check("err_queue_empty", 32'(err_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pixel_conf_sequencer.md
Name: pixel_conf_sequencer

Overview:
Sequences per-pixel 8-bit configuration writes and readbacks over the shared core configuration bus: 12-bit address {row[5:0], region[3:0], pixel[1:0]}, write strobe, 8-bit write data, and the OR-combined read data returned from the core.
- Sits in the digital chip bottom between the command decoder and the core-column configuration bus.
- Accepts burst commands, auto-increments the pixel address, and enforces setup/strobe/hold timing so pixel latches see stable address and data.

Parameters:
SETUP_CYC, 1, cycles address/data are stable before the strobe (1..7)
WR_CYC, 1, strobe high width in cycles (1..7)
HOLD_CYC, 1, cycles address/data are held after the strobe falls (1..7)
RD_CYC, 2, settling cycles for the read OR-tree before sampling (1..7)
MAX_ROW, 47, highest valid core row address

Ports:
Clk  in  1  system clock
ResetB  in  1  asynchronous active-low reset
CmdValid  in  1  command request
CmdReady  out  1  sequencer can accept a command
CmdWrite  in  1  1 = write, 0 = read
CmdAddr  in  12  start address; 12'hFFF = broadcast
CmdData  in  8  write data, applied to every beat of a burst
CmdLen  in  6  number of beats minus 1 (0..63)
Abort  in  1  stop the burst after the current beat
AddressConfOut  out  12  configuration bus address
ConfWrOut  out  1  pixel write strobe
DataConfWr  out  8  configuration bus write data
DataConfRegions  in  8  OR-tree read data from the core
RdValid  out  1  one-cycle pulse: RdData/RdAddr valid
RdData  out  8  sampled pixel configuration
RdAddr  out  12  address of RdData
Busy  out  1  sequencer is not IDLE
ErrPulse  out  1  one-cycle pulse: command rejected
WrapFlag  out  1  sticky: burst wrapped past MAX_ROW; cleared by the next accepted command

Behaviour:
- Reset values: all outputs 0 except CmdReady = 1; state = IDLE. Reset forces ConfWrOut to 0 asynchronously, including mid-strobe.
- States: IDLE, SETUP, STROBE, HOLD, RDWAIT, DONE.
- CmdReady = 1 only in IDLE. A command is accepted on a clock edge with CmdValid & CmdReady; its fields are registered at that edge.
- Rejection rules, checked at acceptance:
  - Read with CmdAddr == 12'hFFF is rejected.
  - CmdAddr row field > MAX_ROW is rejected, unless CmdAddr == 12'hFFF.
  - A rejected command causes ErrPulse = 1 in cycle 1, no bus activity, and a stay in IDLE.
- Write beat, counting from cycle 1 after acceptance:
  - SETUP for SETUP_CYC cycles: AddressConfOut and DataConfWr driven, ConfWrOut = 0.
  - STROBE for WR_CYC cycles: ConfWrOut = 1.
  - HOLD for HOLD_CYC cycles: ConfWrOut = 0, address and data unchanged.
- Read beat:
  - SETUP for SETUP_CYC cycles, then RDWAIT for RD_CYC cycles.
  - DataConfRegions is sampled at the last RDWAIT edge.
  - RdValid pulses in the next cycle with RdData and RdAddr = beat address. No backpressure.
  - The next beat's SETUP overlaps that RdValid cycle.
- All outputs are registered; ConfWrOut has no glitches.
- DataConfWr = 0 outside write beats.
- AddressConfOut holds its last value in IDLE.
- Burst: CmdLen+1 beats, back-to-back with no idle cycle. The address increments after each beat:
  - pixel + 1;
  - on pixel 3 → 0: region + 1;
  - on region 15 → 0: row + 1;
  - on row MAX_ROW → 0: set WrapFlag and continue.
- Broadcast write (12'hFFF): exactly one beat; CmdLen is ignored; no increment.
- Abort: sampled every cycle while not IDLE. It takes effect at the end of the current beat. A strobe is never truncated. An Abort that arrives in the final beat has no extra effect.
- After the last beat the sequencer enters DONE for one cycle (Busy = 1, CmdReady = 0), then IDLE. Earliest next accept is in the cycle after DONE.
- Simultaneous CmdValid and Abort in IDLE: the command is accepted; Abort is ignored.

Decomposition:
- Package rd53_conf_pkg:
  - conf_addr_t packed struct {row[5:0], region[3:0], pixel[1:0]};
  - CONF_BROADCAST = 12'hFFF;
  - seq_state_e enum;
  - REGIONS_PER_CORE = 16, PIXELS_PER_REGION = 4.
- Sub-module conf_addr_incr: combinational next-address with a wrap output, parameterised by MAX_ROW.
- Phase timing uses one 3-bit down-counter inside the top module.

Test Plan:
- Single write, CmdAddr = 12'h0A7, CmdData = 8'h5C, default parameters, accepted at edge 0 → AddressConfOut = 12'h0A7 and DataConfWr = 8'h5C in cycles 1–3; ConfWrOut = 1 only in cycle 2; DONE in cycle 4; CmdReady = 1 in cycle 5.
- Write burst, CmdAddr = 12'h03E, CmdLen = 3 → beat addresses 03E, 03F, 040, 041; four strobes spaced 3 cycles apart; WrapFlag = 0.
- Read burst, CmdAddr = 12'h000, CmdLen = 1, DataConfRegions = 8'hA5 then 8'h3C → RdValid in cycles 4 and 7 with (000, A5) and (001, 3C).
- Wrap case, CmdAddr = {6'd47, 4'd15, 2'd3}, CmdLen = 1 → second beat at 12'h000; WrapFlag = 1 until the next accept.
- Broadcast read → ErrPulse in cycle 1, ConfWrOut never high. Broadcast write with CmdLen = 5 → exactly one strobe.
- Abort raised during the STROBE of beat 0 of an 8-beat write → exactly one full-width strobe, then DONE and IDLE. ResetB low mid-STROBE → ConfWrOut = 0 immediately, CmdReady = 1.
